// File: rtl/mpf_to_buffer_sm.sv
// Streams a contiguous run of cache lines from MPF into a downstream buffer,
// throttling read requests so the buffer can never be overrun.

package mpf_to_buffer_sm_pkg;

  localparam int CCI_CLADDR_WIDTH = 42;
  localparam int CCI_CLDATA_WIDTH = 512;
  localparam int CCI_MDATA_WIDTH  = 16;

  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;
  typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_clData;

  localparam logic [3:0] eREQ_RDLINE_I = 4'h0;
  localparam logic [3:0] eREQ_RDLINE_S = 4'h1;
  localparam logic [3:0] eRSP_RDLINE   = 4'h0;
  localparam logic [3:0] eRSP_UMSG     = 4'h4;

  typedef struct packed {
    logic [1:0]                 vc_sel;
    logic [1:0]                 rsvd1;
    logic [1:0]                 cl_len;
    logic [3:0]                 req_type;
    logic [5:0]                 rsvd0;
    t_cci_clAddr                address;
    logic [CCI_MDATA_WIDTH-1:0] mdata;
  } t_cci_c0_ReqMemHdr;

  typedef struct packed {
    logic rsvd;
    logic checkLoadStoreOrder;
    logic mapVAtoPhysChannel;
    logic addrIsVirtual;
  } t_cci_mpf_ReqMemHdrExt;

  typedef struct packed {
    t_cci_mpf_ReqMemHdrExt ext;
    t_cci_c0_ReqMemHdr     base;
  } t_cci_mpf_c0_ReqMemHdr;

  localparam int CCI_MPF_C0TX_MEMHDR_WIDTH = $bits(t_cci_mpf_c0_ReqMemHdr);

  typedef struct packed {
    logic [1:0]                 vc_used;
    logic                       rsvd1;
    logic                       hit_miss;
    logic [1:0]                 rsvd0;
    logic [1:0]                 cl_num;
    logic [3:0]                 resp_type;
    logic [CCI_MDATA_WIDTH-1:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_cci_clData        data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

endpackage

module mpf_to_buffer_sm
  import mpf_to_buffer_sm_pkg::*;
#(
  parameter int BUFFER_DEPTH    = 512,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 run,
  input  logic [63:0]                          data_length,
  output logic                                 done,
  input  t_cci_clAddr                          first_clAddr,
  input  logic                                 c0TxAlmFull,
  output logic                                 c0TxValid,
  output logic [CCI_MPF_C0TX_MEMHDR_WIDTH-1:0] reqMemHdr,
  input  t_if_ccip_c0_Rx                       c0Rx,
  output logic                                 buffer_wr_enable,
  output logic [CCI_CLDATA_WIDTH-1:0]          buffer_wr_data,
  input  logic [CNT_W-1:0]                     buffer_count
);

  localparam int SUM_W = CNT_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [31:0]      MAX_OUT_U = 32'(MAX_OUTSTANDING);
  localparam logic [SUM_W-1:0] DEPTH_U   = SUM_W'(BUFFER_DEPTH);

  logic [1:0]       state;
  t_cci_clAddr      next_clAddr;
  logic [63:0]      req_cnt;
  logic [63:0]      rsp_cnt;
  logic [CNT_W-1:0] outstanding;

  logic             start;
  logic             issue;
  logic             rd_rsp;
  logic             last_issue;
  logic             last_rsp;
  logic             below_max;
  logic             has_room;
  logic [SUM_W-1:0] occupancy_next;

  // Read header with MPF defaults: virtual address, VA->PA channel mapping on.
  function automatic t_cci_mpf_c0_ReqMemHdr rd_hdr(input t_cci_clAddr addr);
    t_cci_mpf_c0_ReqMemHdr h;
    h                        = '0;
    h.ext.addrIsVirtual      = 1'b1;
    h.ext.mapVAtoPhysChannel = 1'b1;
    h.base.req_type          = eREQ_RDLINE_I;
    h.base.address           = addr;
    return h;
  endfunction

  // One extra bit of headroom keeps the occupancy sum from wrapping.
  assign occupancy_next = {1'b0, outstanding} + {1'b0, buffer_count} + SUM_W'(1);
  assign below_max      = 32'(outstanding) < MAX_OUT_U;
  assign has_room       = occupancy_next <= DEPTH_U;

  assign start      = (state == IDLE) && run && (data_length != 64'd0);
  assign issue      = (state == REQ) && !c0TxAlmFull && below_max && has_room;
  assign rd_rsp     = (state != IDLE) && c0Rx.rspValid && (c0Rx.hdr.resp_type == eRSP_RDLINE);
  assign last_issue = issue && ((req_cnt + 64'd1) == data_length);
  assign last_rsp   = rd_rsp && ((rsp_cnt + 64'd1) == data_length);

  assign done = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= REQ;
        REQ:     if (last_issue) state <= WAIT;
        WAIT:    if (last_rsp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_clAddr <= '0;
      req_cnt     <= '0;
      rsp_cnt     <= '0;
    end else if (start) begin
      next_clAddr <= first_clAddr;
      req_cnt     <= '0;
      rsp_cnt     <= '0;
    end else begin
      if (issue) begin
        next_clAddr <= next_clAddr + 1'b1;
        req_cnt     <= req_cnt + 64'd1;
      end
      if (rd_rsp) rsp_cnt <= rsp_cnt + 64'd1;
    end
  end

  // An issue and a response in the same cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (start) begin
      outstanding <= '0;
    end else begin
      case ({issue, rd_rsp})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c0TxValid        <= 1'b0;
      reqMemHdr        <= '0;
      buffer_wr_enable <= 1'b0;
      buffer_wr_data   <= '0;
    end else begin
      c0TxValid        <= issue;
      buffer_wr_enable <= rd_rsp;
      if (issue)  reqMemHdr      <= rd_hdr(next_clAddr);
      if (rd_rsp) buffer_wr_data <= c0Rx.data;
    end
  end

  logic unused_rx_fields;
  assign unused_rx_fields = ^{c0Rx.mmioRdValid, c0Rx.mmioWrValid, c0Rx.hdr.vc_used,
                              c0Rx.hdr.rsvd1, c0Rx.hdr.hit_miss, c0Rx.hdr.rsvd0,
                              c0Rx.hdr.cl_num, c0Rx.hdr.mdata};

endmodule

// File: tb/tb_mpf_to_buffer_sm.sv
// Scoreboard bench for mpf_to_buffer_sm: a memory responder answers every read
// in order, and a negedge monitor checks requests and buffer writes against queues.
module tb_mpf_to_buffer_sm;
  import mpf_to_buffer_sm_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXO  = 4;
  localparam int CNTW  = 4;
  localparam int LAT   = 3;

  logic                                 clk;
  logic                                 reset;
  logic                                 run;
  logic [63:0]                          data_length;
  logic                                 done;
  t_cci_clAddr                          first_clAddr;
  logic                                 c0TxAlmFull;
  logic                                 c0TxValid;
  logic [CCI_MPF_C0TX_MEMHDR_WIDTH-1:0] reqMemHdr;
  t_if_ccip_c0_Rx                       c0Rx;
  logic                                 buffer_wr_enable;
  logic [511:0]                         buffer_wr_data;
  logic [CNTW-1:0]                      buffer_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int inflight = 0;
  int xfer_reqs = 0, xfer_first = 0, xfer_last = 0;
  int writes_seen = 0;
  int late_writes = 0;
  logic alm_prev = 1'b0;

  t_cci_clAddr  exp_addr_q[$];
  logic [511:0] exp_data_q[$];
  t_cci_clAddr  pend_addr_q[$];
  int           pend_t_q[$];

  mpf_to_buffer_sm #(
    .BUFFER_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .data_length(data_length), .done(done),
    .first_clAddr(first_clAddr), .c0TxAlmFull(c0TxAlmFull), .c0TxValid(c0TxValid),
    .reqMemHdr(reqMemHdr), .c0Rx(c0Rx), .buffer_wr_enable(buffer_wr_enable),
    .buffer_wr_data(buffer_wr_data), .buffer_count(buffer_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected header: ext {rsvd,lso,mapVA,isVirtual}=0011, vc/cl_len/req_type/rsvd all 0.
  function automatic logic [CCI_MPF_C0TX_MEMHDR_WIDTH-1:0] exp_hdr(input t_cci_clAddr a);
    return {4'b0011, 2'b00, 2'b00, 2'b00, 4'h0, 6'h00, a, 16'h0000};
  endfunction

  function automatic logic [511:0] line_of(input t_cci_clAddr a);
    logic [63:0] w;
    w = {22'h0, a} ^ 64'h5A5A_0000_C3C3_0000;
    return {w, ~w, w + 64'd1, w, w ^ 64'hFF, w, w, w};
  endfunction

  function automatic int limit_now();
    int room;
    room = DEPTH - int'(buffer_count);
    return (room < MAXO) ? room : MAXO;
  endfunction

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_bound(input string name, input int act, input int bound);
    n_checks++;
    if (act <= bound) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected at most %0d", name, act, bound);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: request check must precede write handling so inflight mirrors the issue-time view.
  initial begin
    forever begin
      @(negedge clk);
      if (alm_prev) check_output("no_req_almfull", 512'(c0TxValid), 512'(0));
      alm_prev = c0TxAlmFull;
      if (c0TxValid) begin
        if (exp_addr_q.size() == 0) begin
          check_output("unexpected_req", 512'(c0TxValid), 512'(0));
        end else begin
          check_output("req_hdr", 512'(reqMemHdr), 512'(exp_hdr(exp_addr_q.pop_front())));
        end
        inflight++;
        check_bound("outstanding", inflight, limit_now());
        pend_addr_q.push_back(reqMemHdr[16 +: CCI_CLADDR_WIDTH]);
        pend_t_q.push_back(cyc + LAT);
        if (xfer_reqs == 0) xfer_first = cyc;
        xfer_last = cyc;
        xfer_reqs++;
      end
      if (buffer_wr_enable) begin
        writes_seen++;
        if (inflight > 0) inflight--;
        if (exp_data_q.size() == 0) begin
          late_writes++;
          check_output("unexpected_write", 512'(buffer_wr_enable), 512'(0));
        end else begin
          check_output("wr_data", buffer_wr_data, exp_data_q.pop_front());
        end
      end
    end
  end

  // Memory responder with interleaved MMIO and UMSG noise the DUT must ignore.
  initial begin
    t_cci_clAddr a;
    c0Rx = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      c0Rx = '0;
      if (pend_t_q.size() > 0 && pend_t_q[0] <= cyc) begin
        a = pend_addr_q.pop_front();
        void'(pend_t_q.pop_front());
        c0Rx.rspValid      = 1'b1;
        c0Rx.hdr.resp_type = eRSP_RDLINE;
        c0Rx.data          = line_of(a);
      end else if (cyc % 7 == 3) begin
        c0Rx.mmioWrValid = 1'b1;
        c0Rx.data        = {16{$urandom}};
      end else if (cyc % 11 == 5) begin
        c0Rx.rspValid      = 1'b1;
        c0Rx.hdr.resp_type = eRSP_UMSG;
        c0Rx.data          = {16{$urandom}};
      end
    end
  end

  task automatic apply_stimulus(input t_cci_clAddr first, input logic [63:0] len);
    t_cci_clAddr a;
    a = first;
    for (longint i = 0; i < longint'(len); i++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(line_of(a));
      a = a + 1'b1;
    end
    xfer_reqs    = 0;
    first_clAddr = first;
    data_length  = len;
    run          = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!(done && exp_data_q.size() == 0) && n < budget) begin
      tick(1);
      n++;
    end
    check_output({name, "_done"}, 512'(done), 512'(1));
    check_output({name, "_writes_left"}, 512'(exp_data_q.size()), 512'(0));
    check_output({name, "_reqs_left"}, 512'(exp_addr_q.size()), 512'(0));
  endtask

  task automatic wait_reqs(input int target, input int budget);
    int n = 0;
    while (xfer_reqs < target && n < budget) begin
      tick(1);
      n++;
    end
    check_output("reqs_reached", 512'(xfer_reqs >= target), 512'(1));
  endtask

  task automatic check_reset_outputs(input string name);
    check_output({name, "_done"}, 512'(done), 512'(1));
    check_output({name, "_valid"}, 512'(c0TxValid), 512'(0));
    check_output({name, "_wr_en"}, 512'(buffer_wr_enable), 512'(0));
    check_output({name, "_hdr"}, 512'(reqMemHdr), 512'(0));
    check_output({name, "_wr_data"}, buffer_wr_data, 512'(0));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    int n;
    reset        = 1'b1;
    run          = 1'b0;
    data_length  = '0;
    first_clAddr = '0;
    c0TxAlmFull  = 1'b0;
    buffer_count = '0;
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(2);

    // Basic four-line transfer, back to back.
    apply_stimulus(42'h1000, 64'd4);
    check_output("busy", 512'(done), 512'(0));
    wait_done("xfer4", 200);
    check_output("xfer4_count", 512'(xfer_reqs), 512'(4));
    check_output("xfer4_consecutive", 512'(xfer_last - xfer_first), 512'(3));

    // Back-pressure held 10 cycles mid-transfer.
    apply_stimulus(42'h2000, 64'd12);
    wait_reqs(3, 100);
    c0TxAlmFull = 1'b1;
    tick(10);
    c0TxAlmFull = 1'b0;
    wait_done("almfull", 400);
    check_output("almfull_count", 512'(xfer_reqs), 512'(12));

    // Nearly-full buffer caps requests in flight at two.
    buffer_count = CNTW'(6);
    apply_stimulus(42'h3000, 64'd16);
    tick(30);
    buffer_count = '0;
    wait_done("bufcap", 600);
    check_output("bufcap_count", 512'(xfer_reqs), 512'(16));

    // Zero-length run is a no-op.
    apply_stimulus(42'h4000, 64'd0);
    for (int i = 0; i < 10; i++) begin
      check_output("zero_len_done", 512'(done), 512'(1));
      tick(1);
    end
    check_output("zero_len_reqs", 512'(xfer_reqs), 512'(0));

    // Address wraps from all-ones to zero.
    apply_stimulus('1, 64'd2);
    wait_done("wrap", 200);
    check_output("wrap_count", 512'(xfer_reqs), 512'(2));

    // Reset after three of eight writes abandons the transfer.
    w0 = writes_seen;
    apply_stimulus(42'h5000, 64'd8);
    n = 0;
    while (writes_seen - w0 < 3 && n < 200) begin
      tick(1);
      n++;
    end
    check_output("three_writes", 512'(writes_seen - w0), 512'(3));
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_addr_q.delete();
    exp_data_q.delete();
    inflight    = 0;
    late_writes = 0;
    tick(1);
    reset = 1'b0;
    n = 0;
    while (pend_t_q.size() > 0 && n < 100) begin
      tick(1);
      n++;
    end
    tick(3);
    check_output("late_writes", 512'(late_writes), 512'(0));
    check_output("midreset_idle", 512'(done), 512'(1));

    // Recovery transfer after the abandoned one.
    apply_stimulus(42'h6000, 64'd3);
    wait_done("recover", 200);
    check_output("recover_count", 512'(xfer_reqs), 512'(3));

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mpf_to_buffer_sm.md
MPF_TO_BUFFER_SM -- requirements
Module: mpf_to_buffer_SM

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 512, capacity of downstream buffer in cache lines.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 64, cap on read requests in flight.
REQ-003 SHALL have parameter CNT_W, default 10, width of buffer occupancy count (holds 0..BUFFER_DEPTH).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port run  input  1  one-cycle start pulse.
REQ-007 SHALL have port data_length  input  64  cache lines to read, held stable while busy.
REQ-008 SHALL have port done  output  1  high when idle.
REQ-009 SHALL have port first_clAddr  input  t_cci_clAddr  first VA read, held stable while busy.
REQ-010 SHALL have port c0TxAlmFull  input  1  MPF read request channel back-pressure.
REQ-011 SHALL have port c0TxValid  output  1  registered read request valid.
REQ-012 SHALL have port reqMemHdr  output  CCI_MPF_C0TX_MEMHDR_WIDTH  registered read header (eREQ_RDLINE_I, mdata 0, default params).
REQ-013 SHALL have port c0Rx  input  t_if_ccip_c0_Rx  MPF response channel (MPF sorts read responses, in order).
REQ-014 SHALL have port buffer_wr_enable  output  1  buffer write strobe.
REQ-015 SHALL have port buffer_wr_data  output  512  line written to buffer.
REQ-016 SHALL have port buffer_count  input  CNT_W  current buffer occupancy.

Function
REQ-017 SHALL implement states IDLE, REQ, WAIT; done = (state == IDLE).
REQ-018 IDLE: run with data_length != 0 SHALL go to REQ, load next_clAddr = first_clAddr, clear req_cnt, rsp_cnt, outstanding.
REQ-019 IDLE: run with data_length == 0 SHALL stay IDLE; done stays 1.
REQ-020 run in REQ or WAIT SHALL be ignored.
REQ-021 issue = (state==REQ) && !c0TxAlmFull && outstanding < MAX_OUTSTANDING && (outstanding + buffer_count + 1) <= BUFFER_DEPTH, arithmetic at CNT_W+1 bits, no overflow.
REQ-022 On issue: c0TxValid = 1 and reqMemHdr for next_clAddr next cycle; next_clAddr += 1; req_cnt += 1.
REQ-023 c0TxValid SHALL be 0 in any cycle following a non-issue cycle.
REQ-024 REQ SHALL go to WAIT in the cycle req_cnt reaches data_length (last issue).
REQ-025 On c0Rx read response: buffer_wr_enable = 1, buffer_wr_data = c0Rx data, exactly one cycle later; rsp_cnt += 1.
REQ-026 outstanding SHALL +1 on issue, -1 on read response, unchanged when both in one cycle.
REQ-027 WAIT SHALL go to IDLE in the cycle rsp_cnt reaches data_length; done high the next cycle.
REQ-028 Non-read responses on c0Rx (e.g. MMIO) SHALL be ignored.
REQ-029 next_clAddr SHALL wrap modulo t_cci_clAddr width without error.
REQ-030 Requests outstanding never exceed min(MAX_OUTSTANDING, BUFFER_DEPTH - buffer_count); buffer SHALL never overflow.

Reset
REQ-031 Reset asserted SHALL immediately force state IDLE, done 1, c0TxValid 0, buffer_wr_enable 0, all counters 0, next_clAddr 0, reqMemHdr 0, buffer_wr_data 0.
REQ-032 Reset mid-operation SHALL abandon the transfer; responses arriving after reset release while IDLE SHALL not write the buffer.

Verification
REQ-033 run, data_length=4, first_clAddr=0x1000, no back-pressure -> 4 requests 0x1000..0x1003 on consecutive cycles, 4 buffer writes, done returns to 1.
REQ-034 c0TxAlmFull held 1 for 10 cycles mid-transfer -> no c0TxValid during hold; resumes at next address, no gap or repeat.
REQ-035 BUFFER_DEPTH=8, buffer_count=6, data_length=16 -> at most 2 outstanding until buffer_count drops.
REQ-036 data_length=0 pulse run -> done never drops, no request issued.
REQ-037 reset asserted after 3 of 8 responses -> all outputs at reset values same cycle, done=1, later responses ignored.
REQ-038 first_clAddr = all-ones, data_length=2 -> addresses all-ones then 0.
